// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA timing generator that scans a 160x144 2-bit
// frame buffer at 3x scale, centred, with a configurable read latency.
module fb_scanout #(
    parameter int unsigned RD_LAT = 2,
    parameter logic [7:0]  SHADE0 = 8'hFF,
    parameter logic [7:0]  SHADE1 = 8'hAA,
    parameter logic [7:0]  SHADE2 = 8'h55,
    parameter logic [7:0]  SHADE3 = 8'h00,
    parameter logic [7:0]  BORDER = 8'h00
) (
    input  logic       rdclock,
    input  logic       reset_n,
    input  logic [1:0] pixel_in,
    output logic [8:0] X_read,
    output logic [8:0] Y_read,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       frame_start
);

    // Stage bit layout: {frame_start, in_area, visible, hs_n, vs_n}
    localparam logic [4:0] StageIdle = 5'b00011;

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [1:0] xph_q, xph_d;
    logic [1:0] yph_q, yph_d;

    logic [4:0] pipe_q [RD_LAT];
    logic [4:0] pipe_d [RD_LAT];
    logic [4:0] cur_stage;
    logic [4:0] tail;

    logic [7:0] gray_q, gray_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic       fs_q, fs_d;

    // Raster counters plus divide-by-3 read address generation for the next cycle.
    always_comb begin
        h_d   = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
        v_d   = v_q;
        x_d   = x_q;
        xph_d = xph_q;
        y_d   = y_q;
        yph_d = yph_q;

        if (h_q == 10'd79) begin
            x_d   = 9'd0;
            xph_d = 2'd0;
        end else if (h_q >= 10'd80 && h_q <= 10'd558) begin
            if (xph_q == 2'd2) begin
                xph_d = 2'd0;
                x_d   = x_q + 9'd1;
            end else begin
                xph_d = xph_q + 2'd1;
            end
        end else begin
            x_d   = 9'd160;
            xph_d = 2'd0;
        end

        // Rows only change at the line wrap, so Y_read is constant across a line.
        if (h_q == 10'd799) begin
            v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
            if (v_q == 10'd23) begin
                y_d   = 9'd0;
                yph_d = 2'd0;
            end else if (v_q >= 10'd24 && v_q <= 10'd454) begin
                if (yph_q == 2'd2) begin
                    yph_d = 2'd0;
                    y_d   = y_q + 9'd1;
                end else begin
                    yph_d = yph_q + 2'd1;
                end
            end else begin
                y_d   = 9'd144;
                yph_d = 2'd0;
            end
        end
    end

    // Timing flags for the current (h,v) and the shift register that delays them.
    always_comb begin
        cur_stage[4] = (h_q == 10'd0) && (v_q == 10'd0);
        cur_stage[3] = (h_q >= 10'd80) && (h_q <= 10'd559) && (v_q >= 10'd24) && (v_q <= 10'd455);
        cur_stage[2] = (h_q < 10'd640) && (v_q < 10'd480);
        cur_stage[1] = !((h_q >= 10'd656) && (h_q <= 10'd751));
        cur_stage[0] = !((v_q >= 10'd490) && (v_q <= 10'd491));
        pipe_d[0]    = cur_stage;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        tail = pipe_q[RD_LAT-1];
    end

    // Output colour/sync selection from the delayed flags and the returned pixel.
    always_comb begin
        gray_d = 8'h00;
        if (tail[2]) begin
            if (tail[3]) begin
                unique case (pixel_in)
                    2'd0:    gray_d = SHADE0;
                    2'd1:    gray_d = SHADE1;
                    2'd2:    gray_d = SHADE2;
                    default: gray_d = SHADE3;
                endcase
            end else begin
                gray_d = BORDER;
            end
        end
        blank_n_d = tail[2];
        hs_d      = tail[1];
        vs_d      = tail[0];
        fs_d      = tail[4];
    end

    // All state, synchronously cleared to the idle raster position.
    always_ff @(posedge rdclock) begin
        if (!reset_n) begin
            h_q       <= 10'd0;
            v_q       <= 10'd0;
            x_q       <= 9'd160;
            y_q       <= 9'd144;
            xph_q     <= 2'd0;
            yph_q     <= 2'd0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= StageIdle;
            end
            gray_q    <= 8'h00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xph_q     <= xph_d;
            yph_q     <= yph_d;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            gray_q    <= gray_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            fs_q      <= fs_d;
        end
    end

    assign X_read      = x_q;
    assign Y_read      = y_q;
    assign vga_r       = gray_q;
    assign vga_g       = gray_q;
    assign vga_b       = gray_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard bench with a latency-accurate frame buffer model.
module tb_fb_scanout;

    localparam int unsigned LAT = 3;
    localparam logic [7:0]  BRD = 8'h10;

    logic       clk;
    logic       reset_n;
    logic [1:0] pixel_in;
    logic [8:0] X_read, Y_read;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, frame_start;

    fb_scanout #(
        .RD_LAT (LAT),
        .BORDER (BRD)
    ) dut (
        .rdclock     (clk),
        .reset_n     (reset_n),
        .pixel_in    (pixel_in),
        .X_read      (X_read),
        .Y_read      (Y_read),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gray;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       fs;
        int         h;
        int         v;
    } pin_t;

    typedef struct {
        int         h;
        int         v;
        logic [8:0] x;
        logic [8:0] y;
    } addr_vec_t;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] gray;
        logic       blank;
    } pin_vec_t;

    pin_t        sb_q[$];
    logic [17:0] addr_hist[$];
    int          hs_fall[$];
    int          hs_rise[$];
    addr_vec_t   avec[9];
    pin_vec_t    pvec[16];

    int   n_cmp, n_bad;
    int   mh, mv, rel_cyc, fs_seen;
    int   avec_hits, pvec_hits;
    logic hs_prev;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (model h=%0d v=%0d)", name, act, exp, mh, mv);
        end
    endtask

    function automatic logic [7:0] shade(input logic [1:0] s);
        case (s)
            2'd0:    return 8'hFF;
            2'd1:    return 8'hAA;
            2'd2:    return 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    // Buffer image: a single dark pixel at (5,5), then shade stripes from row 8 down.
    function automatic logic [1:0] pat(input int x, input int y);
        if (x == 5 && y == 5) return 2'd3;
        if (y >= 8) return 2'(x % 4);
        return 2'd0;
    endfunction

    task automatic cycle_body();
        pin_t        e, p;
        logic [17:0] a;
        int          ex, ey;
        logic        vis, area;

        ex = (mh >= 80 && mh <= 559) ? (mh - 80) / 3 : 160;
        ey = (mv >= 24 && mv <= 455) ? (mv - 24) / 3 : 144;
        chk("x_read", int'(X_read), ex);
        chk("y_read", int'(Y_read), ey);
        foreach (avec[i]) begin
            if (avec[i].h == mh && avec[i].v == mv) begin
                avec_hits++;
                chk("vec_x_read", int'(X_read), int'(avec[i].x));
                chk("vec_y_read", int'(Y_read), int'(avec[i].y));
            end
        end

        vis     = (mh < 640) && (mv < 480);
        area    = (mh >= 80) && (mh <= 559) && (mv >= 24) && (mv <= 455);
        e.gray  = !vis ? 8'h00 : (area ? shade(pat((mh - 80) / 3, (mv - 24) / 3)) : BRD);
        e.blank = vis;
        e.hs    = !(mh >= 656 && mh <= 751);
        e.vs    = !(mv >= 490 && mv <= 491);
        e.fs    = (mh == 0) && (mv == 0);
        e.h     = mh;
        e.v     = mv;
        sb_q.push_back(e);

        p = sb_q.pop_front();
        chk("vga_r", int'(vga_r), int'(p.gray));
        chk("vga_g", int'(vga_g), int'(p.gray));
        chk("vga_b", int'(vga_b), int'(p.gray));
        chk("blank_n", int'(vga_blank_n), int'(p.blank));
        chk("vga_hs", int'(vga_hs), int'(p.hs));
        chk("vga_vs", int'(vga_vs), int'(p.vs));
        chk("frame_start", int'(frame_start), int'(p.fs));
        foreach (pvec[i]) begin
            if (pvec[i].h == p.h && pvec[i].v == p.v) begin
                pvec_hits++;
                chk("vec_gray", int'(vga_r), int'(pvec[i].gray));
                chk("vec_blank_n", int'(vga_blank_n), int'(pvec[i].blank));
            end
        end

        if (frame_start && fs_seen < 0) fs_seen = rel_cyc;
        if (hs_prev && !vga_hs) hs_fall.push_back(rel_cyc);
        if (!hs_prev && vga_hs) hs_rise.push_back(rel_cyc);
        hs_prev = vga_hs;

        // Frame buffer returns data for the address presented LAT cycles earlier.
        addr_hist.push_back({X_read, Y_read});
        pixel_in = 2'($urandom_range(0, 3));
        if (addr_hist.size() > LAT) begin
            a = addr_hist.pop_front();
            if (a[17:9] < 9'd160 && a[8:0] < 9'd144) pixel_in = pat(int'(a[17:9]), int'(a[8:0]));
        end

        if (mh == 799) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        rel_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle_body();
    endtask

    task automatic do_reset(input int n);
        pin_t r;
        reset_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("rst_x_read", int'(X_read), 160);
            chk("rst_y_read", int'(Y_read), 144);
            chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
            chk("rst_hs", int'(vga_hs), 1);
            chk("rst_vs", int'(vga_vs), 1);
            chk("rst_blank_n", int'(vga_blank_n), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            pixel_in = 2'($urandom_range(0, 3));
        end
        reset_n = 1'b1;
        mh      = 0;
        mv      = 0;
        rel_cyc = 0;
        fs_seen = -1;
        hs_prev = 1'b1;
        sb_q.delete();
        addr_hist.delete();
        hs_fall.delete();
        hs_rise.delete();
        r = '{gray: 8'h00, blank: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, h: -1, v: -1};
        for (int k = 0; k <= LAT; k++) sb_q.push_back(r);
        cycle_body();
    endtask

    initial begin
        int guard;
        clk       = 1'b0;
        reset_n   = 1'b0;
        pixel_in  = 2'd0;
        n_cmp     = 0;
        n_bad     = 0;
        avec_hits = 0;
        pvec_hits = 0;

        avec[0] = '{80, 24, 9'd0, 9'd0};
        avec[1] = '{82, 24, 9'd0, 9'd0};
        avec[2] = '{83, 24, 9'd1, 9'd0};
        avec[3] = '{559, 24, 9'd159, 9'd0};
        avec[4] = '{560, 24, 9'd160, 9'd0};
        avec[5] = '{79, 24, 9'd160, 9'd0};
        avec[6] = '{100, 10, 9'd6, 9'd144};
        avec[7] = '{0, 23, 9'd160, 9'd144};
        avec[8] = '{300, 50, 9'd73, 9'd8};

        pvec[0]  = '{95, 39, 8'h00, 1'b1};
        pvec[1]  = '{97, 41, 8'h00, 1'b1};
        pvec[2]  = '{94, 39, 8'hFF, 1'b1};
        pvec[3]  = '{98, 39, 8'hFF, 1'b1};
        pvec[4]  = '{95, 38, 8'hFF, 1'b1};
        pvec[5]  = '{95, 42, 8'hFF, 1'b1};
        pvec[6]  = '{40, 30, 8'h10, 1'b1};
        pvec[7]  = '{700, 30, 8'h00, 1'b0};
        pvec[8]  = '{80, 48, 8'hFF, 1'b1};
        pvec[9]  = '{83, 48, 8'hAA, 1'b1};
        pvec[10] = '{86, 48, 8'h55, 1'b1};
        pvec[11] = '{89, 48, 8'h00, 1'b1};
        pvec[12] = '{79, 30, 8'h10, 1'b1};
        pvec[13] = '{560, 30, 8'h10, 1'b1};
        pvec[14] = '{640, 30, 8'h00, 1'b0};
        pvec[15] = '{100, 23, 8'h10, 1'b1};

        do_reset(3);

        // Run until just past h=400 on line 50 so the table points and stripes are covered.
        guard = 0;
        while (!(mh == 400 && mv == 50) && guard < 60000) begin
            tick();
            guard++;
        end
        chk("run_reached_target", guard, 50 * 800 + 400 - 1);
        chk("frame_start_first", fs_seen, LAT + 1);
        chk("hs_fall_0", (hs_fall.size() > 0) ? hs_fall[0] : -1, 656 + LAT + 1);
        chk("hs_rise_0", (hs_rise.size() > 0) ? hs_rise[0] : -1, 752 + LAT + 1);
        chk("hs_fall_1", (hs_fall.size() > 1) ? hs_fall[1] : -1, 656 + 800 + LAT + 1);
        chk("hs_fall_count", hs_fall.size(), 50);
        chk("addr_vec_hits", avec_hits, 9);
        chk("pin_vec_hits", pvec_hits, 16);

        // One-cycle reset in the middle of the frame.
        do_reset(1);
        repeat (26 * 800) tick();
        chk("frame_start_after_rst", fs_seen, LAT + 1);
        chk("hs_fall_after_rst", (hs_fall.size() > 0) ? hs_fall[0] : -1, 656 + LAT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter RD_LAT, default 2: clocks from X_read/Y_read presented to matching pixel_in valid.
REQ-002 Parameter SHADE0/SHADE1/SHADE2/SHADE3, defaults 8'hFF/8'hAA/8'h55/8'h00: gray level per 2-bit shade.
REQ-003 Parameter BORDER, default 8'h00: gray level outside game area, inside visible region.
REQ-004 rdclock  in  1  pixel clock (25.175 MHz nominal), sole clock, all logic on rising edge.
REQ-005 reset_n  in  1  reset; synchronous and active-low.
REQ-006 pixel_in  in  2  shade read from active frame buffer.
REQ-007 X_read  out  9  frame buffer read column, 0..159 in area, 160 otherwise.
REQ-008 Y_read  out  9  frame buffer read row, 0..143 in area rows, 144 otherwise.
REQ-009 vga_r, vga_g, vga_b  out  8 each  pixel color.
REQ-010 vga_hs, vga_vs  out  1 each  syncs, active-low.
REQ-011 vga_blank_n  out  1  high in visible 640x480 region.
REQ-012 frame_start  out  1  one-cycle pulse, first visible pixel of frame at output pins.

Function
REQ-013 Internal counters h 0..799, v 0..524; h increments every cycle; h 799->0 increments v; v 524->0 on h wrap.
REQ-014 Timing: visible h 0..639, v 0..479; hsync h 656..751; vsync v 490..491.
REQ-015 Game area: h 80..559 and v 24..455 (3x scale of 160x144, centered).
REQ-016 X_read = (h-80)/3 floor in h 80..559, else 160; Y_read = (v-24)/3 floor in v 24..455, else 144, independent of h.
REQ-017 X_read/Y_read are register outputs for the current cycle's (h,v); divide-by-3 via phase counters (0..2), no divider or multiplier.
REQ-018 Row phase advances once per line at h wrap; X_read/Y_read never glitch, never exceed 160/144.
REQ-019 Out-of-area sentinels 160/144 guarantee buffer-swap logic sees Y_read>=144 throughout vertical blanking and border rows.
REQ-020 Sync, blank, in-area, frame-start delayed by RD_LAT-stage shift register so all align with pixel_in.
REQ-021 Output registers: state for (h,v) of cycle n appears at pins in cycle n+RD_LAT+1.
REQ-022 Color: in area, r=g=b=SHADE[pixel_in]; visible but outside area, r=g=b=BORDER; not visible, r=g=b=0, vga_blank_n=0.
REQ-023 frame_start high exactly when pins show (h,v)=(0,0); one cycle per 420000.
REQ-024 pixel_in ignored outside area; X/Y never read outside 0..159/0..143 while marked in-area.

Reset
REQ-025 reset_n low at an edge: h=v=0, phase counters 0, pipeline stages cleared to non-visible/syncs inactive, all in same cycle.
REQ-026 Values while/after reset: X_read=160, Y_read=144, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0.
REQ-027 Reset mid-frame restarts at (0,0); no partial sync pulse after release, except one legitimately produced by new counters.
REQ-028 First edge with reset_n high advances h to 1; pipeline refills over RD_LAT+1 cycles showing blank values.

Verification
REQ-029 Release reset, RD_LAT=2 -> frame_start at cycle 3; vga_hs low cycles 659..754 each line, period 800; vga_vs low 1600 cycles every 420000.
REQ-030 Address sweep -> (h,v)=(80,24): X=0,Y=0; h=82: X=0; h=83: X=1; h=559: X=159; h=560: X=160; v=455: Y=143; v=456: Y=144; v=0..23: Y=144.
REQ-031 pixel_in=2'b11 for X_read=(5,5), else 2'b00 -> pins: 0x00 for 3x3 block at h 95..97, v 39..41; 0xFF elsewhere in area.
REQ-032 Border: (h,v)=(40,200), BORDER=8'h10 -> r=g=b=0x10, vga_blank_n=1; (h,v)=(700,200) -> 0x00, vga_blank_n=0.
REQ-033 Latency: RD_LAT=3, pixel_in changes only in cycle n+3 -> pins change cycle n+4, aligned with h=80 area start.
REQ-034 reset_n low one cycle at v=300,h=400 -> next cycle outputs per REQ-026; frame_start reappears exactly RD_LAT+1 cycles after release.
